// File: rtl/voice_sequencer.sv
// Time-multiplexed voice scheduler: walks every voice through read / process / write-back,
// then takes a bounded burst of parameter updates at the frame boundary. Optional VOICE_SEQ_ACTIVE_SKIP_EN.
module voice_sequencer #(
    parameter int NUM_VOICES = 256,
    parameter int VOICE_W    = $clog2(NUM_VOICES),
    parameter int STATE_W    = 32,
    parameter int PARAM_W    = 32,
    parameter int MAX_UPD    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic [VOICE_W-1:0] voice_idx,
    output logic [STATE_W-1:0] voice_state,
    output logic [PARAM_W-1:0] voice_param,
    output logic               proc_valid,
    input  logic               proc_done,
    input  logic [STATE_W-1:0] proc_state,
    input  logic               proc_release,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [VOICE_W-1:0] upd_voice,
    input  logic [PARAM_W-1:0] upd_param,
    input  logic               upd_gate,
    output logic               frame_tick,
    output logic               busy
);
    // state   | meaning
    // CLEAR   | zero one memory entry per cycle after reset
    // IDLE    | waiting for enable, counter restarts at voice 0
    // READ    | memory address = counter
    // PROC    | voice presented downstream until proc_done
    // WRITE   | write latched result back to the state memory
    // UPDATE  | accept up to MAX_UPD parameter updates

    localparam int UPD_W = $clog2(MAX_UPD + 1);
    localparam logic [VOICE_W-1:0] LAST_VOICE = VOICE_W'(NUM_VOICES - 1);
    localparam logic [UPD_W-1:0]   LAST_UPD   = UPD_W'(MAX_UPD - 1);

    if (NUM_VOICES < 2) begin : g_bad_voices
        $error("voice_sequencer: NUM_VOICES must be at least 2");
    end
    if (MAX_UPD < 1) begin : g_bad_upd
        $error("voice_sequencer: MAX_UPD must be at least 1");
    end

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_READ,
        S_PROC,
        S_WRITE,
        S_UPDATE
    } fsm_t;

    fsm_t fsm_state;
    fsm_t fsm_next;

    logic [STATE_W-1:0]    state_mem [NUM_VOICES];
    logic [PARAM_W-1:0]    param_mem [NUM_VOICES];
    logic [NUM_VOICES-1:0] active;
    logic [NUM_VOICES-1:0] clr_mask;
    logic [NUM_VOICES-1:0] set_mask;
    logic [VOICE_W-1:0]    cnt;
    logic [UPD_W-1:0]      upd_cnt;
    logic [STATE_W-1:0]    wb_state;
    logic                  upd_accept;
    logic                  upd_in_range;
    logic                  last_voice;
    logic                  skip_voice;

    assign last_voice   = (cnt == LAST_VOICE);
    assign upd_in_range = ({1'b0, upd_voice} < (VOICE_W + 1)'(NUM_VOICES));

`ifdef VOICE_SEQ_ACTIVE_SKIP_EN
    assign skip_voice = !active[cnt];
`else
    assign skip_voice = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_state <= S_CLEAR;
        end else begin
            fsm_state <= fsm_next;
        end
    end

    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            S_CLEAR: begin
                if (last_voice) begin
                    fsm_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (enable) begin
                    fsm_next = S_READ;
                end
            end
            S_READ: begin
                if (!skip_voice) begin
                    fsm_next = S_PROC;
                end else if (last_voice) begin
                    fsm_next = S_UPDATE;
                end else begin
                    fsm_next = enable ? S_READ : S_IDLE;
                end
            end
            S_PROC: begin
                if (proc_done) begin
                    fsm_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_voice) begin
                    fsm_next = S_UPDATE;
                end else begin
                    fsm_next = enable ? S_READ : S_IDLE;
                end
            end
            S_UPDATE: begin
                // The burst closes on the first idle requester or on the MAX_UPD-th acceptance.
                if (!upd_valid || (upd_cnt == LAST_UPD)) begin
                    fsm_next = enable ? S_READ : S_IDLE;
                end
            end
            default: fsm_next = S_CLEAR;
        endcase
    end

    always_comb begin
        proc_valid = (fsm_state == S_PROC);
        upd_ready  = (fsm_state == S_UPDATE);
        busy       = (fsm_state != S_IDLE);
        frame_tick = (fsm_state == S_UPDATE) && (upd_cnt == '0);
        upd_accept = (fsm_state == S_UPDATE) && upd_valid;
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        case (fsm_state)
            S_CLEAR: clr_mask = NUM_VOICES'(1) << cnt;
            S_PROC: begin
                if (proc_done && proc_release) begin
                    clr_mask = NUM_VOICES'(1) << voice_idx;
                end
            end
            S_UPDATE: begin
                if (upd_accept && upd_in_range && upd_gate) begin
                    set_mask = NUM_VOICES'(1) << upd_voice;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            upd_cnt     <= '0;
            voice_idx   <= '0;
            voice_state <= '0;
            voice_param <= '0;
            wb_state    <= '0;
            active      <= '0;
        end else begin
            active <= (active & ~clr_mask) | set_mask;
            case (fsm_state)
                S_CLEAR: cnt <= last_voice ? '0 : cnt + VOICE_W'(1);
                S_IDLE:  cnt <= '0;
                S_READ: begin
                    if (skip_voice) begin
                        cnt <= last_voice ? '0 : cnt + VOICE_W'(1);
                    end else begin
                        voice_idx   <= cnt;
                        voice_state <= state_mem[cnt];
                        voice_param <= param_mem[cnt];
                    end
                end
                S_PROC: begin
                    if (proc_done) begin
                        wb_state <= proc_state;
                    end
                end
                S_WRITE: begin
                    if (!last_voice) begin
                        cnt <= cnt + VOICE_W'(1);
                    end
                end
                S_UPDATE: begin
                    if (upd_accept) begin
                        upd_cnt <= upd_cnt + UPD_W'(1);
                    end
                    if (fsm_next != S_UPDATE) begin
                        cnt     <= '0;
                        upd_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Writes are suppressed while reset is high so an aborted voice never lands in memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (fsm_state)
                S_CLEAR: begin
                    state_mem[cnt] <= '0;
                    param_mem[cnt] <= '0;
                end
                S_WRITE: state_mem[cnt] <= wb_state;
                S_UPDATE: begin
                    if (upd_accept && upd_in_range) begin
                        param_mem[upd_voice] <= upd_param;
                        if (upd_gate) begin
                            state_mem[upd_voice] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_voice_sequencer.sv
// Bench for voice_sequencer: a frame-level model builds the whole cycle schedule (stimulus plus
// expected outputs) up front, then one process plays it and another compares every cycle.
module tb_voice_sequencer;
    localparam int N  = 5;
    localparam int VW = $clog2(N);
    localparam int SW = 16;
    localparam int PW = 16;
    localparam int MU = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          proc_done = 1'b0;
    logic          proc_release = 1'b0;
    logic          upd_valid = 1'b0;
    logic          upd_gate = 1'b0;
    logic [VW-1:0] upd_voice = '0;
    logic [SW-1:0] proc_state = '0;
    logic [PW-1:0] upd_param = '0;
    logic [VW-1:0] voice_idx;
    logic [SW-1:0] voice_state;
    logic [PW-1:0] voice_param;
    logic          proc_valid;
    logic          upd_ready;
    logic          frame_tick;
    logic          busy;

    always #5 clk = ~clk;

    voice_sequencer #(
        .NUM_VOICES(N), .VOICE_W(VW), .STATE_W(SW), .PARAM_W(PW), .MAX_UPD(MU)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .voice_idx(voice_idx), .voice_state(voice_state), .voice_param(voice_param),
        .proc_valid(proc_valid), .proc_done(proc_done), .proc_state(proc_state),
        .proc_release(proc_release), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_voice(upd_voice), .upd_param(upd_param), .upd_gate(upd_gate),
        .frame_tick(frame_tick), .busy(busy)
    );

    typedef struct {
        bit rst; bit en; bit done; bit rel; bit uval; bit ugate;
        logic [VW-1:0] uvoice; logic [SW-1:0] pstate; logic [PW-1:0] uparam;
        bit chk; bit chk_data; bit pv; bit rdy; bit tick; bit bsy;
        logic [VW-1:0] idx; logic [SW-1:0] st; logic [PW-1:0] pm;
        int tag;
    } cyc_t;

    typedef struct { logic [VW-1:0] v; logic [PW-1:0] p; bit g; } upd_t;

    cyc_t          sched[$];
    upd_t          pend[$];
    logic [SW-1:0] m_state [N];
    logic [PW-1:0] m_param [N];
    bit            m_active [N];
    int            want_tag [N];
    int            want_utag;
    logic [SW-1:0] cap_state [16];
    logic [PW-1:0] cap_param [16];
    logic [VW-1:0] cap_uvoice [16];
    int            compared = 0;
    int            mismatched = 0;

    cyc_t cur;
    bit   have = 0;
    int   cyc = 0;
    int   tick_cyc[$];
    int   acc[$];
    int   first_pv = -1;
    int   run = 0;
    int   max_run = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic cyc_t base(bit tied);
        cyc_t e;
        e.rst = 0; e.en = 1; e.done = tied; e.rel = 0;
        e.pstate = SW'($urandom);
        e.uval   = (pend.size() > 0);
        e.uvoice = e.uval ? pend[0].v : VW'($urandom);
        e.uparam = e.uval ? pend[0].p : PW'($urandom);
        e.ugate  = e.uval ? pend[0].g : 1'($urandom_range(0, 1));
        e.chk = 1; e.chk_data = 0; e.pv = 0; e.rdy = 0; e.tick = 0; e.bsy = 1;
        e.idx = '0; e.st = '0; e.pm = '0; e.tag = 0;
        return e;
    endfunction

    task automatic push_upd(int v, int p, bit g);
        upd_t u;
        u.v = VW'(v); u.p = PW'(p); u.g = g;
        pend.push_back(u);
    endtask

    task automatic apply_upd(upd_t u);
        if (int'(u.v) < N) begin
            m_param[u.v] = u.p;
            if (u.g) begin
                m_state[u.v]  = '0;
                m_active[u.v] = 1;
            end
        end
    endtask

    // Reset cycles beyond the first, N clear cycles, idle_wait idle cycles, one idle cycle with enable.
    task automatic gen_after_reset(int extra, int idle_wait);
        cyc_t e;
        for (int i = 0; i < N; i++) begin
            m_state[i] = '0; m_param[i] = '0; m_active[i] = 0;
        end
        for (int i = 0; i < extra + N + idle_wait + 1; i++) begin
            e = base(1'b0);
            e.rst = (i < extra);
            e.en = (i >= extra + N + idle_wait);
            e.chk_data = 1;
            e.bsy = (i < extra + N);
            sched.push_back(e);
        end
    endtask

    task automatic gen_frame(bit tied, bit rt, int stall_v, int stall_len, int rst_v);
        cyc_t e;
        int d;
        logic [SW-1:0] pst;
        bit rel;
        bit skip;
        for (int v = 0; v < N; v++) begin
`ifdef VOICE_SEQ_ACTIVE_SKIP_EN
            skip = !m_active[v];
`else
            skip = 0;
`endif
            e = base(tied);
            sched.push_back(e);
            if (!skip) begin
                d   = (v == stall_v) ? stall_len : (tied ? 0 : int'($urandom_range(0, 2)));
                pst = rt ? m_state[v] + SW'(1) : SW'($urandom);
                rel = rt ? 1'b0 : 1'($urandom_range(0, 1));
                for (int k = 0; k <= d; k++) begin
                    e = base(tied);
                    e.pv = 1; e.chk_data = 1;
                    e.idx = VW'(v); e.st = m_state[v]; e.pm = m_param[v];
                    e.done = (k == d); e.pstate = pst; e.rel = rel;
                    if (k == 0) e.tag = want_tag[v];
                    if (k == d && v == rst_v) begin
                        e.rst = 1;
                        sched.push_back(e);
                        gen_after_reset(1, 2);
                        return;
                    end
                    sched.push_back(e);
                end
                m_state[v] = pst;
                if (rel) m_active[v] = 0;
                e = base(tied);
                sched.push_back(e);
            end
        end
        for (int j = 0; j < MU; j++) begin
            e = base(tied);
            e.rdy = 1; e.tick = (j == 0);
            if (j == 0) e.tag = want_utag;
            sched.push_back(e);
            if (!e.uval) break;
            apply_upd(pend.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (have) begin
            if (cur.chk) begin
                check("proc_valid", 32'(proc_valid), 32'(cur.pv));
                check("upd_ready", 32'(upd_ready), 32'(cur.rdy));
                check("frame_tick", 32'(frame_tick), 32'(cur.tick));
                check("busy", 32'(busy), 32'(cur.bsy));
                if (cur.chk_data) begin
                    check("voice_idx", 32'(voice_idx), 32'(cur.idx));
                    check("voice_state", 32'(voice_state), 32'(cur.st));
                    check("voice_param", 32'(voice_param), 32'(cur.pm));
                end
            end
            if (cur.tag != 0) begin
                cap_state[cur.tag]  = voice_state;
                cap_param[cur.tag]  = voice_param;
                cap_uvoice[cur.tag] = upd_voice;
            end
            if (frame_tick) begin
                tick_cyc.push_back(cyc);
                acc.push_back(0);
            end
            if (upd_valid && upd_ready && acc.size() > 0) acc[$] = acc[$] + 1;
            if (proc_valid) begin
                run++;
                if (first_pv < 0) first_pv = cyc;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            cyc++;
        end
    end

    initial begin
        cyc_t e;
        int n;
        for (int i = 0; i < N; i++) want_tag[i] = 0;
        want_utag = 0;

        e = base(1'b0); e.rst = 1; e.chk = 0;
        sched.push_back(e);
        gen_after_reset(1, 0);
        gen_frame(1, 1, -1, 0, -1);
        gen_frame(1, 1, -1, 0, -1);
        want_tag[2] = 1;
        gen_frame(1, 1, -1, 0, -1);
        want_tag[2] = 0;
        gen_frame(1, 1, 1, 5, -1);
        push_upd(1, 'hA5, 1); push_upd(3, 'h5A, 0); push_upd(0, 'h11, 0);
        gen_frame(1, 1, -1, 0, -1);
        want_tag[1] = 2; want_utag = 3;
        gen_frame(1, 1, -1, 0, -1);
        want_tag[1] = 0;
        push_upd(7, 'h77, 1); push_upd(2, 'h22, 0); push_upd(4, 'h44, 0);
        want_utag = 7;
        gen_frame(0, 0, -1, 0, -1);
        want_utag = 0; want_tag[2] = 4; want_tag[4] = 5;
        gen_frame(0, 0, -1, 0, -1);
        want_tag[2] = 0; want_tag[4] = 0;
        gen_frame(0, 0, -1, 0, 2);
        want_tag[2] = 6;
        gen_frame(0, 0, -1, 0, -1);
        want_tag[2] = 0;
        for (int f = 0; f < 8; f++) begin
            n = int'($urandom_range(0, 3));
            for (int i = 0; i < n; i++)
                push_upd(int'($urandom_range(0, 7)), int'($urandom), 1'($urandom_range(0, 1)));
            gen_frame(0, 0, -1, 0, -1);
        end

        while (sched.size() > 0) begin
            @(posedge clk);
            #1;
            e = sched.pop_front();
            reset = e.rst; enable = e.en;
            proc_done = e.done; proc_release = e.rel; proc_state = e.pstate;
            upd_valid = e.uval; upd_voice = e.uvoice; upd_param = e.uparam; upd_gate = e.ugate;
            cur = e;
            have = 1;
        end
        @(posedge clk);
        #1;
        have = 0;

`ifndef VOICE_SEQ_ACTIVE_SKIP_EN
        // Hand-computed anchors for N=5, MAX_UPD=2.
        check("tick_count", 32'(tick_cyc.size()), 32'd17);
        if (tick_cyc.size() >= 8 && first_pv > 0) begin
            check("tick_after_first_read", 32'(tick_cyc[0] - (first_pv - 1)), 32'd15);
            check("frame2_length", 32'(tick_cyc[1] - tick_cyc[0]), 32'd16);
            check("stall_frame_length", 32'(tick_cyc[3] - tick_cyc[2]), 32'd21);
            check("burst_accepts", 32'(acc[4]), 32'd2);
            check("leftover_accepts", 32'(acc[5]), 32'd1);
            check("oor_burst_accepts", 32'(acc[6]), 32'd2);
        end else begin
            check("tick_history_present", 32'(tick_cyc.size()), 32'd17);
        end
        check("stall_pv_run", 32'(max_run), 32'd6);
        check("roundtrip_v2_frame3", 32'(cap_state[1]), 32'd2);
        check("burst_v1_param", 32'(cap_param[2]), 32'hA5);
        check("burst_v1_state", 32'(cap_state[2]), 32'd0);
        check("leftover_voice_at_tick", 32'(cap_uvoice[3]), 32'd0);
        check("oor_voice_at_tick", 32'(cap_uvoice[7]), 32'd7);
        check("v2_param_after_oor", 32'(cap_param[4]), 32'h22);
        check("v4_param_still_pending", 32'(cap_param[5]), 32'd0);
        check("v2_state_after_reset", 32'(cap_state[6]), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
